// File: rtl/clock_mode_ctrl.sv
// Wall-clock timekeeping and set-time/mode controller: h:m:s counters, RUN/SET_HOUR/SET_MIN FSM, 12/24 h remap.
// Optional digit blinking while setting is enabled by defining CLOCK_CTRL_BLINK_EN.
module clock_mode_ctrl #(
  parameter bit          START_24H  = 1'b0,
  parameter int unsigned RESET_HOUR = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_set,
  input  logic       btn_inc,
  output logic [4:0] hour_disp,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       flag_pm,
  output logic       flag_24h,
  output logic       setting_hour,
  output logic       setting_min,
  output logic       blank_hour,
  output logic       blank_min
);

  typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN} state_t;

  state_t     state;
  logic [4:0] hour;

  function automatic logic [5:0] inc_mod60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc_mod24(input logic [4:0] v);
    return (v == 5'd23) ? 5'd0 : v + 5'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      hour     <= 5'(RESET_HOUR);
      minutes  <= 6'd0;
      seconds  <= 6'd0;
      flag_24h <= START_24H;
    end else begin
      if (btn_mode)
        flag_24h <= ~flag_24h;
      case (state)
        RUN: begin
          // Ripple carry: 23:59:59 wraps to 00:00:00 on a single tick
          if (tick_1hz) begin
            seconds <= inc_mod60(seconds);
            if (seconds == 6'd59) begin
              minutes <= inc_mod60(minutes);
              if (minutes == 6'd59)
                hour <= inc_mod24(hour);
            end
          end
          if (btn_set)
            state <= SET_HOUR;
        end
        SET_HOUR: begin
          if (btn_set)
            state <= SET_MIN;
          else if (btn_inc)
            hour <= inc_mod24(hour);
        end
        SET_MIN: begin
          if (btn_set) begin
            state   <= RUN;
            seconds <= 6'd0;
          end else if (btn_inc) begin
            minutes <= inc_mod60(minutes);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    hour_disp = hour;
    if (!flag_24h) begin
      if (hour == 5'd0)
        hour_disp = 5'd12;
      else if (hour > 5'd12)
        hour_disp = hour - 5'd12;
    end
  end

  assign flag_pm      = (hour >= 5'd12);
  assign setting_hour = (state == SET_HOUR);
  assign setting_min  = (state == SET_MIN);

`ifdef CLOCK_CTRL_BLINK_EN
  logic blink_phase;

  // Any state change (btn_set) restarts the blink phase at 0; it only runs while setting
  always_ff @(posedge clk) begin
    if (rst)
      blink_phase <= 1'b0;
    else if (btn_set || state == RUN || state == 2'd3)
      blink_phase <= 1'b0;
    else if (tick_1hz)
      blink_phase <= ~blink_phase;
  end

  assign blank_hour = setting_hour & blink_phase;
  assign blank_min  = setting_min & blink_phase;
`else
  assign blank_hour = 1'b0;
  assign blank_min  = 1'b0;
`endif

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl: directed scenarios plus random stimulus against a time-of-day model.
module tb_clock_mode_ctrl;

  localparam bit TB_START_24H  = 1'b0;
  localparam int TB_RESET_HOUR = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0, btn_mode = 1'b0, btn_set = 1'b0, btn_inc = 1'b0;
  logic [4:0] hour_disp;
  logic [5:0] minutes, seconds;
  logic       flag_pm, flag_24h, setting_hour, setting_min, blank_hour, blank_min;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: time of day as seconds since midnight, state 0=run 1=set hour 2=set minute
  int tod;
  int mst;
  bit mblink;
  bit m24;

  clock_mode_ctrl #(.START_24H(TB_START_24H), .RESET_HOUR(TB_RESET_HOUR)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .btn_mode(btn_mode), .btn_set(btn_set),
    .btn_inc(btn_inc), .hour_disp(hour_disp), .minutes(minutes), .seconds(seconds),
    .flag_pm(flag_pm), .flag_24h(flag_24h), .setting_hour(setting_hour),
    .setting_min(setting_min), .blank_hour(blank_hour), .blank_min(blank_min)
  );

  always #5 clk = ~clk;

  function automatic int m_h();   return tod / 3600;       endfunction
  function automatic int m_m();   return (tod / 60) % 60;  endfunction
  function automatic int m_s();   return tod % 60;         endfunction
  function automatic int exp_disp();
    if (m24) return m_h();
    return (m_h() % 12 == 0) ? 12 : m_h() % 12;
  endfunction
  function automatic bit exp_blank(input int st);
`ifdef CLOCK_CTRL_BLINK_EN
    return (mst == st) && mblink;
`else
    return 1'b0 && (st == mst);
`endif
  endfunction

  task automatic drive(input bit r, input bit t, input bit md, input bit st, input bit inc);
    rst = r; tick_1hz = t; btn_mode = md; btn_set = st; btn_inc = inc;
    if (r) begin
      tod = TB_RESET_HOUR * 3600; mst = 0; mblink = 0; m24 = TB_START_24H;
    end else begin
      if (md) m24 = !m24;
      case (mst)
        0: begin
          if (t) tod = (tod + 1) % 86400;
          if (st) begin mst = 1; mblink = 0; end
        end
        1: begin
          if (st) begin mst = 2; mblink = 0; end
          else begin
            if (inc) tod = ((m_h() + 1) % 24) * 3600 + tod % 3600;
            if (t) mblink = !mblink;
          end
        end
        default: begin
          if (st) begin tod = tod - m_s(); mst = 0; mblink = 0; end
          else begin
            if (inc) tod = m_h() * 3600 + ((m_m() + 1) % 60) * 60 + m_s();
            if (t) mblink = !mblink;
          end
        end
      endcase
    end
    @(posedge clk); #1;
    rst = 0; tick_1hz = 0; btn_mode = 0; btn_set = 0; btn_inc = 0;
  endtask

  // Navigate from RUN through the set FSM to h:m:00, back in RUN
  task automatic set_time(input int h, input int m);
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 24 && m_h() != h; i++) drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 60 && m_m() != m; i++) drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 0);
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0);
    tests_run++; if (hour_disp !== 5'd12) begin tests_failed++; $display("FAIL reset_hour_disp got %0d want 12", hour_disp); end
    tests_run++; if (minutes !== 6'd0 || seconds !== 6'd0) begin tests_failed++; $display("FAIL reset_ms got %0d:%0d want 0:0", minutes, seconds); end
    tests_run++; if ({flag_pm, flag_24h, setting_hour, setting_min, blank_hour, blank_min} !== 6'b0) begin
      tests_failed++; $display("FAIL reset_flags got %b want 000000", {flag_pm, flag_24h, setting_hour, setting_min, blank_hour, blank_min}); end
    drive(0, 1, 0, 0, 0);
    tests_run++; if (seconds !== 6'd1 || minutes !== 6'd0 || hour_disp !== 5'd12) begin
      tests_failed++; $display("FAIL first_tick got %0d:%0d:%0d want 12:0:1", hour_disp, minutes, seconds); end
  endtask

  task automatic test_rollover();
    set_time(23, 59);
    for (int i = 0; i < 59; i++) drive(0, 1, 0, 0, 0);
    tests_run++; if (hour_disp !== 5'd11 || minutes !== 6'd59 || seconds !== 6'd59 || flag_pm !== 1'b1) begin
      tests_failed++; $display("FAIL preload_235959 got %0d:%0d:%0d pm=%b want 11:59:59 pm=1", hour_disp, minutes, seconds, flag_pm); end
    drive(0, 1, 0, 0, 0);
    tests_run++; if (hour_disp !== 5'd12 || minutes !== 6'd0 || seconds !== 6'd0 || flag_pm !== 1'b0) begin
      tests_failed++; $display("FAIL midnight_wrap got %0d:%0d:%0d pm=%b want 12:0:0 pm=0", hour_disp, minutes, seconds, flag_pm); end
  endtask

  task automatic test_mode();
    set_time(13, 0);
    tests_run++; if (hour_disp !== 5'd1 || flag_pm !== 1'b1 || flag_24h !== 1'b0) begin
      tests_failed++; $display("FAIL hour13_12h got disp=%0d pm=%b 24h=%b want 1 1 0", hour_disp, flag_pm, flag_24h); end
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    tests_run++; if (hour_disp !== 5'd13 || flag_24h !== 1'b1 || seconds !== 6'd2 || flag_pm !== 1'b1) begin
      tests_failed++; $display("FAIL mode_toggle got disp=%0d 24h=%b s=%0d pm=%b want 13 1 2 1", hour_disp, flag_24h, seconds, flag_pm); end
  endtask

  task automatic test_set_hour();
    set_time(22, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    tests_run++; if (setting_hour !== 1'b1 || setting_min !== 1'b0) begin
      tests_failed++; $display("FAIL enter_set_hour got sh=%b sm=%b want 1 0", setting_hour, setting_min); end
    drive(0, 0, 0, 0, 1);
    tests_run++; if (hour_disp !== 5'd23) begin tests_failed++; $display("FAIL inc_hour_23 got %0d want 23", hour_disp); end
    drive(0, 0, 0, 0, 1);
    tests_run++; if (hour_disp !== 5'd0 || minutes !== 6'd0 || seconds !== 6'd3) begin
      tests_failed++; $display("FAIL inc_hour_wrap got %0d:%0d:%0d want 0:0:3", hour_disp, minutes, seconds); end
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 0, 0);
      tests_run++; if (seconds !== 6'd3 || blank_hour !== exp_blank(1) || blank_min !== 1'b0) begin
        tests_failed++; $display("FAIL set_hour_tick%0d got s=%0d bh=%b bm=%b want 3 %b 0", i, seconds, blank_hour, blank_min, exp_blank(1)); end
    end
  endtask

  task automatic test_set_min_simul();
    drive(0, 0, 0, 1, 0);
    tests_run++; if (setting_min !== 1'b1 || setting_hour !== 1'b0 || blank_min !== 1'b0) begin
      tests_failed++; $display("FAIL enter_set_min got sm=%b sh=%b bm=%b want 1 0 0", setting_min, setting_hour, blank_min); end
    for (int i = 0; i < 60 && m_m() != 59; i++) drive(0, 0, 0, 0, 1);
    tests_run++; if (minutes !== 6'd59 || hour_disp !== 5'd0) begin
      tests_failed++; $display("FAIL inc_min_59 got %0d:%0d want 0:59", hour_disp, minutes); end
    drive(0, 0, 0, 1, 1);
    tests_run++; if (setting_min !== 1'b0 || setting_hour !== 1'b0 || minutes !== 6'd59 || seconds !== 6'd0) begin
      tests_failed++; $display("FAIL set_wins_inc got sm=%b sh=%b m=%0d s=%0d want 0 0 59 0", setting_min, setting_hour, minutes, seconds); end
  endtask

  task automatic test_reset_mid_set();
    set_time(5, 10);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 1, 0, 0, 0);
    tests_run++; if (setting_min !== 1'b1 || minutes !== 6'd10 || blank_min !== exp_blank(2)) begin
      tests_failed++; $display("FAIL pre_rst_set_min got sm=%b m=%0d bm=%b want 1 10 %b", setting_min, minutes, blank_min, exp_blank(2)); end
    drive(1, 0, 0, 0, 0);
    tests_run++; if (setting_min !== 1'b0 || blank_min !== 1'b0 || setting_hour !== 1'b0) begin
      tests_failed++; $display("FAIL rst_mid_set_state got sm=%b bm=%b sh=%b want 0 0 0", setting_min, blank_min, setting_hour); end
    tests_run++; if (hour_disp !== 5'd12 || minutes !== 6'd0 || seconds !== 6'd0 || flag_24h !== 1'b0) begin
      tests_failed++; $display("FAIL rst_mid_set_time got %0d:%0d:%0d 24h=%b want 12:0:0 0", hour_disp, minutes, seconds, flag_24h); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0);
      tests_run++; if (hour_disp !== 5'(exp_disp()) || minutes !== 6'(m_m()) || seconds !== 6'(m_s())) begin
        tests_failed++; $display("FAIL rand_time cyc %0d got %0d:%0d:%0d want %0d:%0d:%0d", i, hour_disp, minutes, seconds, exp_disp(), m_m(), m_s()); end
      tests_run++; if (flag_pm !== (m_h() >= 12) || flag_24h !== m24 || setting_hour !== (mst == 1) || setting_min !== (mst == 2)) begin
        tests_failed++; $display("FAIL rand_flags cyc %0d got pm=%b 24h=%b sh=%b sm=%b want %b %b %b %b", i,
          flag_pm, flag_24h, setting_hour, setting_min, m_h() >= 12, m24, mst == 1, mst == 2); end
      tests_run++; if (blank_hour !== exp_blank(1) || blank_min !== exp_blank(2)) begin
        tests_failed++; $display("FAIL rand_blank cyc %0d got bh=%b bm=%b want %b %b", i, blank_hour, blank_min, exp_blank(1), exp_blank(2)); end
    end
  endtask

  initial begin
    tod = 0; mst = 0; mblink = 0; m24 = 0;
    @(posedge clk); #1;
    test_reset();
    test_rollover();
    test_mode();
    test_set_hour();
    test_set_min_simul();
    test_reset_mid_set();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
